// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Error-check constants are used only when DMR_CHECK_EN is defined.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmr_state_e;

    localparam logic [1:0]  DMR_ALIGN_MASK     = 2'b11;
    localparam int unsigned DMR_BYTES_PER_WORD = 4;

    // Little-endian lane pick, sign-extended to a full word.
    function automatic logic [31:0] lane_sext(
        input logic [31:0] word,
        input logic [1:0]  lane
    );
        logic [7:0] b;
        b = word[8*lane +: 8];
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dmr_bytelane.sv
// Store-merge and load-extract for byte or word accesses on lanes 0-3.
module dmr_bytelane
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    output logic [31:0] merge_o,
    output logic [31:0] load_o
);

    always_comb begin
        merge_o = wdata_i;
        load_o  = word_i;
        if (byte_i) begin
            merge_o                = word_i;
            merge_o[8*lane_i +: 8] = wdata_i[7:0];
            load_o                 = lane_sext(word_i, lane_i);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and valid/ready response.
// Define DMR_CHECK_EN to reject misaligned word and out-of-range accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_DMR_reqValid,
    input  logic        i_DMR_reqWe,
    input  logic        i_DMR_reqByte,
    input  logic [31:0] i_DMR_reqAddr,
    input  logic [31:0] i_DMR_reqWData,
    output logic        o_DMR_reqReady,
    output logic        o_DMR_rspValid,
    input  logic        i_DMR_rspReady,
    output logic [31:0] o_DMR_rspRData,
    output logic        o_DMR_rspErr
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmr_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        init_q;
    logic        we_q, byte_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          accept, commit;
    logic          c_we, c_byte, c_err;
    logic [31:0]   c_addr, c_wdata;
    logic [AW-1:0] c_idx;
    logic [31:0]   merged, loaded;

    assign o_DMR_reqReady = init_q && (state_q == IDLE);
    assign o_DMR_rspValid = (state_q == RESP);
    assign o_DMR_rspRData = rdata_q;
    assign o_DMR_rspErr   = err_q;
    assign accept = i_DMR_reqValid && o_DMR_reqReady;

    // With zero wait states the commit happens on the acceptance edge.
    assign c_we    = (state_q == IDLE) ? i_DMR_reqWe    : we_q;
    assign c_byte  = (state_q == IDLE) ? i_DMR_reqByte  : byte_q;
    assign c_addr  = (state_q == IDLE) ? i_DMR_reqAddr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? i_DMR_reqWData : wdata_q;
    assign c_idx   = c_addr[AW+1:2];

`ifdef DMR_CHECK_EN
    assign c_err = (!c_byte && ((c_addr[1:0] & DMR_ALIGN_MASK) != 2'b00))
                || (c_addr >= 32'(DMR_BYTES_PER_WORD * DEPTH));
`else
    logic unused_addr;
    assign unused_addr = ^c_addr[31:AW+2];
    assign c_err = 1'b0;
`endif

    dmr_bytelane u_lane (
        .word_i  (mem[c_idx]),
        .wdata_i (c_wdata),
        .lane_i  (c_addr[1:0]),
        .byte_i  (c_byte),
        .merge_o (merged),
        .load_o  (loaded)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_DMR_rspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_we) ? 32'd0 : loaded;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            init_q  <= 1'b0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= i_DMR_reqWe;
                byte_q  <= i_DMR_reqByte;
                addr_q  <= i_DMR_reqAddr;
                wdata_q <= i_DMR_reqWData;
            end
        end
    end

    // Array is not reset; a reset before commit leaves it untouched.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) mem[c_idx] <= merged;
    end

endmodule
